// File: rtl/sram_pkg.sv
// Shared definitions for the sram arbiter slice: default widths and port-select encoding.
package sram_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 14;
   localparam int CNT_WIDTH_DEF  = 16;
   localparam int NUM_PORTS      = 2;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   // The port that gets priority next after 'winner' has been served.
   function automatic port_t other_port(input port_t winner);
      return (winner == PORT_A) ? PORT_B : PORT_A;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant plus a registered priority pointer.
module rr_arb2
   import sram_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   port_t prio_reg;
   port_t prio_next;

   always_comb begin
      gnt       = 2'b00;
      prio_next = prio_reg;
      // Nothing is granted while reset is held so no access leaks out.
      if (!reset) begin
         if (req[0] && (!req[1] || prio_reg == PORT_A)) begin
            gnt[0] = 1'b1;
         end else if (req[1]) begin
            gnt[1] = 1'b1;
         end
      end
      if (gnt[0]) begin
         prio_next = other_port(PORT_A);
      end else if (gnt[1]) begin
         prio_next = other_port(PORT_B);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_reg <= PORT_A;
      end else begin
         prio_reg <= prio_next;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port, 1-cycle-latency sram between two requesters with round-robin
// arbitration; read data is steered back to the port that issued the read.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,

   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,

   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   input  logic [DATA_WIDTH-1:0] sram_rdata,

   output logic [CNT_WIDTH-1:0]  contention_cnt
);

   logic [NUM_PORTS-1:0]  req_vec;
   logic [NUM_PORTS-1:0]  gnt_vec;
   logic                  we_vec     [NUM_PORTS];
   logic [ADDR_WIDTH-1:0] addr_vec   [NUM_PORTS];
   logic [DATA_WIDTH-1:0] wdata_vec  [NUM_PORTS];
   logic                  pend_reg   [NUM_PORTS];
   logic                  rvalid_vec [NUM_PORTS];
   logic [DATA_WIDTH-1:0] rdata_vec  [NUM_PORTS];

   logic [CNT_WIDTH-1:0]  cnt_reg;
   logic [CNT_WIDTH-1:0]  cnt_next;

   assign req_vec      = {b_req, a_req};
   assign we_vec[0]    = a_we;
   assign we_vec[1]    = b_we;
   assign addr_vec[0]  = a_addr;
   assign addr_vec[1]  = b_addr;
   assign wdata_vec[0] = a_wdata;
   assign wdata_vec[1] = b_wdata;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req_vec),
      .gnt   (gnt_vec)
   );

   assign a_gnt = gnt_vec[0];
   assign b_gnt = gnt_vec[1];

   // Grant is one-hot, so the loop simply selects the winner's command.
   always_comb begin
      sram_en    = |gnt_vec;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gnt_vec[i]) begin
            sram_we    = we_vec[i];
            sram_addr  = addr_vec[i];
            sram_wdata = wdata_vec[i];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
         always_ff @(posedge clk) begin
            if (reset) begin
               pend_reg[gi] <= 1'b0;
            end else begin
               pend_reg[gi] <= gnt_vec[gi] & ~we_vec[gi];
            end
         end

         // A response still in flight when reset arrives is dropped, not presented.
         assign rvalid_vec[gi] = pend_reg[gi] & ~reset;
         assign rdata_vec[gi]  = rvalid_vec[gi] ? sram_rdata : '0;
      end
   endgenerate

   assign a_rvalid = rvalid_vec[0];
   assign a_rdata  = rdata_vec[0];
   assign b_rvalid = rvalid_vec[1];
   assign b_rdata  = rdata_vec[1];

   always_comb begin
      cnt_next = cnt_reg;
      if (a_req && b_req && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
         cnt_next = cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign contention_cnt = cnt_reg;

endmodule
